res_station: RTL

RES_STATION -- requirements
Module: res_station

---
 rtl/res_station.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/res_station.sv
// res_station: reservation station feeding a single ALU.
//
// Holds up to DEPTH dispatched instructions. Each entry keeps its opcode,
// destination ROB tag and, per operand, a ready bit plus separate value and
// wait-tag fields. Result broadcasts on the CDB wake waiting operands. Each
// cycle the oldest fully-ready entry is issued through registered outputs.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable (low = stall everything)
//   flush             discard all entries
//   in_*              dispatch request (valid, op, tag, per-operand rdy/v/q)
//   full, free_cnt    occupancy, derived from registered used bits only
//   cdb_valid/tag/data  NCDB packed broadcast channels, channel 0 in LSBs
//   out_*             registered issue: one-cycle out_valid pulse plus payload
module res_station #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int DATA_W = 32,
    parameter int NCDB   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [OP_W-1:0]              in_op,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic                         in_rdy1,
    input  logic                         in_rdy2,
    input  logic [DATA_W-1:0]            in_v1,
    input  logic [DATA_W-1:0]            in_v2,
    input  logic [TAG_W-1:0]             in_q1,
    input  logic [TAG_W-1:0]             in_q2,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   free_cnt,
    input  logic [NCDB-1:0]              cdb_valid,
    input  logic [NCDB*TAG_W-1:0]        cdb_tag,
    input  logic [NCDB*DATA_W-1:0]       cdb_data,
    output logic                         out_valid,
    output logic [OP_W-1:0]              out_op,
    output logic [TAG_W-1:0]             out_tag,
    output logic [DATA_W-1:0]            out_v1,
    output logic [DATA_W-1:0]            out_v2
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Entry storage
    logic [DEPTH-1:0]  used_q, used_d;
    logic [DEPTH-1:0]  rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [OP_W-1:0]   op_q [DEPTH];
    logic [OP_W-1:0]   op_d [DEPTH];
    logic [TAG_W-1:0]  tag_q [DEPTH];
    logic [TAG_W-1:0]  tag_d [DEPTH];
    logic [DATA_W-1:0] v1_q [DEPTH];
    logic [DATA_W-1:0] v1_d [DEPTH];
    logic [DATA_W-1:0] v2_q [DEPTH];
    logic [DATA_W-1:0] v2_d [DEPTH];
    logic [TAG_W-1:0]  q1_q [DEPTH];
    logic [TAG_W-1:0]  q1_d [DEPTH];
    logic [TAG_W-1:0]  q2_q [DEPTH];
    logic [TAG_W-1:0]  q2_d [DEPTH];

    // Age matrix: age_q[i][j]=1 means entry j was dispatched before entry i.
    // Relative ordering has no counter, so it cannot wrap.
    logic [DEPTH-1:0]  age_q [DEPTH];
    logic [DEPTH-1:0]  age_d [DEPTH];

    // Registered issue port
    logic              outValid_q, outValid_d;
    logic [OP_W-1:0]   outOp_q, outOp_d;
    logic [TAG_W-1:0]  outTag_q, outTag_d;
    logic [DATA_W-1:0] outV1_q, outV1_d;
    logic [DATA_W-1:0] outV2_q, outV2_d;

    // Returns {hit, data}; the loop runs high-to-low so the lowest channel wins.
    function automatic logic [DATA_W:0] cdbLookup(
        input logic [TAG_W-1:0]       tag,
        input logic [NCDB-1:0]        valid,
        input logic [NCDB*TAG_W-1:0]  tags,
        input logic [NCDB*DATA_W-1:0] data
    );
        logic [DATA_W:0] result;
        result = '0;
        for (int c = NCDB - 1; c >= 0; c--) begin
            if (valid[c] && (tags[c*TAG_W +: TAG_W] == tag)) begin
                result = {1'b1, data[c*DATA_W +: DATA_W]};
            end
        end
        return result;
    endfunction

    // Wakeup match for every stored wait tag
    logic [DEPTH-1:0]  wake1Hit, wake2Hit;
    logic [DATA_W-1:0] wake1Data [DEPTH];
    logic [DATA_W-1:0] wake2Data [DEPTH];

    always_comb begin
        wake1Hit  = '0;
        wake2Hit  = '0;
        wake1Data = '{default: '0};
        wake2Data = '{default: '0};
        for (int i = 0; i < DEPTH; i++) begin
            {wake1Hit[i], wake1Data[i]} = cdbLookup(q1_q[i], cdb_valid, cdb_tag, cdb_data);
            {wake2Hit[i], wake2Data[i]} = cdbLookup(q2_q[i], cdb_valid, cdb_tag, cdb_data);
        end
    end

    // Same-cycle bypass for the incoming request's operands
    logic [DATA_W:0] disp1Lookup, disp2Lookup;
    assign disp1Lookup = cdbLookup(in_q1, cdb_valid, cdb_tag, cdb_data);
    assign disp2Lookup = cdbLookup(in_q2, cdb_valid, cdb_tag, cdb_data);

    // Occupancy and lowest free slot, from registered used bits only
    logic [CNT_W-1:0] freeCnt;
    logic [IDX_W-1:0] freeIdx;

    always_comb begin
        freeCnt = '0;
        freeIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!used_q[i]) begin
                freeIdx = IDX_W'(i);
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!used_q[i]) begin
                freeCnt = freeCnt + CNT_W'(1);
            end
        end
    end

    assign free_cnt = freeCnt;
    assign full     = (freeCnt == '0);

    logic dispatchEn;
    assign dispatchEn = rdy && !flush && in_valid && !full;

    // Oldest candidate: no other candidate is older than it
    logic [DEPTH-1:0] cand;
    logic             issueValid;
    logic [IDX_W-1:0] issueIdx;

    assign cand       = used_q & rdy1_q & rdy2_q;
    assign issueValid = |cand;

    always_comb begin
        issueIdx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i] && ((age_q[i] & cand) == '0)) begin
                issueIdx = IDX_W'(i);
            end
        end
    end

    // Next state: stall holds everything, flush clears occupancy, otherwise
    // wakeup, issue and dispatch touch disjoint entries in the same cycle.
    always_comb begin
        used_d     = used_q;
        rdy1_d     = rdy1_q;
        rdy2_d     = rdy2_q;
        op_d       = op_q;
        tag_d      = tag_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        q1_d       = q1_q;
        q2_d       = q2_q;
        age_d      = age_q;
        outValid_d = 1'b0;
        outOp_d    = outOp_q;
        outTag_d   = outTag_q;
        outV1_d    = outV1_q;
        outV2_d    = outV2_q;

        if (rdy) begin
            if (flush) begin
                used_d = '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (used_q[i] && !rdy1_q[i] && wake1Hit[i]) begin
                        rdy1_d[i] = 1'b1;
                        v1_d[i]   = wake1Data[i];
                    end
                    if (used_q[i] && !rdy2_q[i] && wake2Hit[i]) begin
                        rdy2_d[i] = 1'b1;
                        v2_d[i]   = wake2Data[i];
                    end
                end

                if (issueValid) begin
                    used_d[issueIdx] = 1'b0;
                    outValid_d       = 1'b1;
                    outOp_d          = op_q[issueIdx];
                    outTag_d         = tag_q[issueIdx];
                    outV1_d          = v1_q[issueIdx];
                    outV2_d          = v2_q[issueIdx];
                end

                // The new entry is younger than everything currently held;
                // clearing its column drops stale "older" marks from the
                // previous occupant of this slot.
                if (dispatchEn) begin
                    used_d[freeIdx] = 1'b1;
                    op_d[freeIdx]   = in_op;
                    tag_d[freeIdx]  = in_tag;
                    q1_d[freeIdx]   = in_q1;
                    q2_d[freeIdx]   = in_q2;
                    rdy1_d[freeIdx] = in_rdy1 || disp1Lookup[DATA_W];
                    rdy2_d[freeIdx] = in_rdy2 || disp2Lookup[DATA_W];
                    v1_d[freeIdx]   = in_rdy1 ? in_v1 : disp1Lookup[DATA_W-1:0];
                    v2_d[freeIdx]   = in_rdy2 ? in_v2 : disp2Lookup[DATA_W-1:0];
                    for (int k = 0; k < DEPTH; k++) begin
                        age_d[k][freeIdx] = 1'b0;
                    end
                    age_d[freeIdx] = used_q;
                end
            end
        end
    end

    // State registers; reset wins over every other control
    always_ff @(posedge clk) begin
        if (rst) begin
            used_q     <= '0;
            rdy1_q     <= '0;
            rdy2_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= '0;
                tag_q[i] <= '0;
                v1_q[i]  <= '0;
                v2_q[i]  <= '0;
                q1_q[i]  <= '0;
                q2_q[i]  <= '0;
                age_q[i] <= '0;
            end
            outValid_q <= 1'b0;
            outOp_q    <= '0;
            outTag_q   <= '0;
            outV1_q    <= '0;
            outV2_q    <= '0;
        end else begin
            used_q     <= used_d;
            rdy1_q     <= rdy1_d;
            rdy2_q     <= rdy2_d;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= op_d[i];
                tag_q[i] <= tag_d[i];
                v1_q[i]  <= v1_d[i];
                v2_q[i]  <= v2_d[i];
                q1_q[i]  <= q1_d[i];
                q2_q[i]  <= q2_d[i];
                age_q[i] <= age_d[i];
            end
            outValid_q <= outValid_d;
            outOp_q    <= outOp_d;
            outTag_q   <= outTag_d;
            outV1_q    <= outV1_d;
            outV2_q    <= outV2_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_op    = outOp_q;
    assign out_tag   = outTag_q;
    assign out_v1    = outV1_q;
    assign out_v2    = outV2_q;

endmodule
